// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of the two requester ports and the data-memory bus
// around the shared data-memory arbiter.
//
// Signals
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : requester -> arbiter
//   gnt0/gnt1, done0/done1, err0/err1              : arbiter -> requester pulses
//   rdata0/rdata1                                  : arbiter -> requester read data
//   memAddr, memWriteData, MemWrite, MemRead       : arbiter -> memory
//   memReadData                                    : memory  -> arbiter
//
// Modports
//   slave  : arbiter view (serves the requesters, drives the memory)
//   master : environment view (requesters plus memory), opposite directions

interface dmem_arbiter_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic        err0;
  logic        err1;
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] memReadData;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, memReadData,
    output gnt0, gnt1, done0, done1, rdata0, rdata1, err0, err1,
    output memAddr, memWriteData, MemWrite, MemRead
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, memReadData,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1, err0, err1,
    input  memAddr, memWriteData, MemWrite, MemRead
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and sequencer for the shared 32-bit data memory
// (MEM_WORDS words, registered read whose output is gated by MemRead).
//
// One word access is serviced at a time:
//   IDLE   -> sample requests, latch the winner's qualifiers
//   ACCESS -> gnt pulse, drive memory address/data/strobe (suppressed if out of range)
//   RESP   -> in-range reads only: hold MemRead/memAddr, capture memReadData
//   DONE   -> done pulse (plus err if out of range)
//
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : dmem_arbiter_if.slave (requester handshakes and memory bus)
//
// Parameters
//   MEM_WORDS : memory depth in words; byte addresses >= MEM_WORDS*4 are errors
//
// Build option
//   DMEM_ARB_RR_EN : when defined, a simultaneous request goes to the port that
//                    was not granted last; otherwise port 0 always wins.

module dmem_arbiter #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  localparam logic [31:0] AddrLimit = 32'(MEM_WORDS * 4);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;  // 0 = port 0, 1 = port 1
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        oor_q, oor_d;      // latched address was out of range
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic        any_req;
  logic        pick1;             // port 1 wins this sample
  logic [31:0] sel_addr;

  assign any_req  = bus.req0 | bus.req1;
  assign sel_addr = pick1 ? bus.addr1 : bus.addr0;

`ifdef DMEM_ARB_RR_EN
  // Last-granted port; resets to port 1 so port 0 wins the first conflict.
  logic last_q, last_d;

  assign pick1 = bus.req1 & (~bus.req0 | ~last_q);

  always_comb begin
    last_d = last_q;
    if (state_q == StIdle && any_req) begin
      last_d = pick1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign pick1 = bus.req1 & ~bus.req0;
`endif

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    oor_d    = oor_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StAccess;
          owner_d = pick1;
          we_d    = pick1 ? bus.we1 : bus.we0;
          addr_d  = sel_addr;
          wdata_d = pick1 ? bus.wdata1 : bus.wdata0;
          // Low address bits are ignored by the memory, so only the upper bound matters.
          oor_d   = (sel_addr >= AddrLimit);
        end
      end

      StAccess: begin
        if (!oor_q && !we_q) begin
          state_d = StResp;
        end else begin
          state_d = StDone;
        end
        // Out-of-range read returns zero, visible together with done.
        if (oor_q && !we_q) begin
          if (owner_q) begin
            rdata1_d = '0;
          end else begin
            rdata0_d = '0;
          end
        end
      end

      StResp: begin
        state_d = StDone;
        if (owner_q) begin
          rdata1_d = bus.memReadData;
        end else begin
          rdata0_d = bus.memReadData;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      oor_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      oor_q    <= oor_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Outputs are decoded from registered state only, so reset clears them at once.
  always_comb begin
    bus.gnt0         = 1'b0;
    bus.gnt1         = 1'b0;
    bus.done0        = 1'b0;
    bus.done1        = 1'b0;
    bus.err0         = 1'b0;
    bus.err1         = 1'b0;
    bus.memAddr      = '0;
    bus.memWriteData = '0;
    bus.MemWrite     = 1'b0;
    bus.MemRead      = 1'b0;

    unique case (state_q)
      StIdle: begin
      end

      StAccess: begin
        bus.gnt0 = ~owner_q;
        bus.gnt1 = owner_q;
        if (!oor_q) begin
          bus.memAddr      = addr_q;
          bus.memWriteData = we_q ? wdata_q : '0;
          bus.MemWrite     = we_q;
          bus.MemRead      = ~we_q;
        end
      end

      StResp: begin
        bus.memAddr = addr_q;
        bus.MemRead = 1'b1;
      end

      StDone: begin
        bus.done0 = ~owner_q;
        bus.done1 = owner_q;
        bus.err0  = ~owner_q & oor_q;
        bus.err1  = owner_q & oor_q;
      end

      default: begin
      end
    endcase
  end

  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;

  // Handshake sanity: one grant at a time, never grant and done together.
  gnt_onehot_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.gnt0 && bus.gnt1));
  gnt_done_excl_a: assert property (@(posedge clk) disable iff (!rst_n)
    !((bus.gnt0 || bus.gnt1) && (bus.done0 || bus.done1)));

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a
// transaction-level model (per-transaction timeline, shadow memory, arbitration rule).

module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.MEM_WORDS(1024)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Data memory: registered read, output gated by MemRead; preloaded while pre_en is high.
  logic [31:0] mem [1024];
  logic [31:0] rd_q = '0;
  logic        pre_en = 1'b0;
  logic [9:0]  pre_idx = '0;
  logic [31:0] seed = '0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B1) ^ seed;
  endfunction

  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_idx] <= init_word(int'(pre_idx));
      pre_idx      <= pre_idx + 10'd1;
    end else begin
      if (bus.MemWrite) mem[bus.memAddr[11:2]] <= bus.memWriteData;
      if (bus.MemRead) rd_q <= mem[bus.memAddr[11:2]];
    end
  end
  assign bus.memReadData = bus.MemRead ? rd_q : 32'h0;

  // Reference state
  logic [31:0] exp_mem [1024];
  logic [31:0] exp_rdata [2];
  int last_gnt = 1;
  int tests = 0;
  int fails = 0;
  int txn_id = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // {gnt1,gnt0,done1,done0,err1,err0,MemWrite,MemRead}
  function automatic logic [31:0] ctrl_obs();
    return {24'h0, bus.gnt1, bus.gnt0, bus.done1, bus.done0, bus.err1, bus.err0,
            bus.MemWrite, bus.MemRead};
  endfunction

  task automatic check_cycle(input string tag, input logic [7:0] ectrl,
                             input logic [31:0] eaddr, input logic [31:0] ewd);
    chk({tag, ".ctrl"}, ctrl_obs(), {24'h0, ectrl});
    chk({tag, ".memAddr"}, bus.memAddr, eaddr);
    chk({tag, ".memWriteData"}, bus.memWriteData, ewd);
    chk({tag, ".rdata0"}, bus.rdata0, exp_rdata[0]);
    chk({tag, ".rdata1"}, bus.rdata1, exp_rdata[1]);
  endtask

  // Arbitration rule from the port's point of view.
  function automatic int pick(input bit r0, input bit r1);
`ifdef DMEM_ARB_RR_EN
    if (r0 && r1) return (last_gnt == 0) ? 1 : 0;
`endif
    return r0 ? 0 : 1;
  endfunction

  task automatic drive(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  // Called at the negedge of an idle cycle with the request already driven.
  // Checks every cycle from grant through the following idle cycle.
  task automatic expect_txn(input int w, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit drop);
    bit oor;
    int len;
    oor = (addr >= 32'd4096);
    len = (!oor && !we) ? 3 : 2;
    txn_id++;
    @(posedge clk);
    for (int k = 1; k <= len + 1; k++) begin
      logic [7:0]  c;
      logic [31:0] ea;
      logic [31:0] ed;
      c = '0; ea = '0; ed = '0;
      @(negedge clk);
      if (k == 1) begin
        c[6 + w] = 1'b1;
        if (!oor) begin
          c[1] = we; c[0] = ~we; ea = addr; ed = we ? wdata : 32'h0;
          if (we) exp_mem[addr[11:2]] = wdata;
        end
      end else if (k == 2 && len == 3) begin
        c[0] = 1'b1; ea = addr;
      end
      if (k == len) begin
        c[4 + w] = 1'b1;
        c[2 + w] = oor;
        if (!we) exp_rdata[w] = oor ? 32'h0 : exp_mem[addr[11:2]];
      end
      check_cycle($sformatf("t%0d.p%0d.k%0d", txn_id, w, k), c, ea, ed);
      if (k == 1 && drop) begin
        if (w == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          pend [2];
    logic        pwe [2];
    logic [31:0] pad [2];
    logic [31:0] pwd [2];
    int          w;

    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
    seed = $urandom;
    for (int i = 0; i < 1024; i++) exp_mem[i] = init_word(i);
    exp_rdata[0] = 0; exp_rdata[1] = 0;
    pre_en = 1'b1;
    repeat (1024) @(posedge clk);
    #1 pre_en = 1'b0;

    // Reset state
    @(negedge clk);
    check_cycle("reset", 8'h00, 32'h0, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Port 0 read of word 4
    drive(0, 1'b0, 32'h10, 32'h0);
    last_gnt = 0;
    expect_txn(0, 1'b0, 32'h10, 32'h0, 1'b1);
    chk("read10.rdata0", bus.rdata0, 32'hDEADBEEF);
    chk("read10.rdata1", bus.rdata1, 32'h0);

    // Port 1 write, then port 0 reads it back
    drive(1, 1'b1, 32'h40, 32'h12345678);
    last_gnt = 1;
    expect_txn(1, 1'b1, 32'h40, 32'h12345678, 1'b1);
    drive(0, 1'b0, 32'h40, 32'h0);
    last_gnt = 0;
    expect_txn(0, 1'b0, 32'h40, 32'h0, 1'b1);
    chk("wr40.rdata0", bus.rdata0, 32'h12345678);

    // Both ports holding read requests continuously
    drive(0, 1'b0, 32'h10, 32'h0);
    drive(1, 1'b0, 32'h44, 32'h0);
    for (int i = 0; i < 4; i++) begin
      w = pick(1'b1, 1'b1);
      last_gnt = w;
      expect_txn(w, 1'b0, (w == 0) ? 32'h10 : 32'h44, 32'h0, 1'b0);
    end
    bus.req0 = 0; bus.req1 = 0;

    // Out-of-range read
    drive(0, 1'b0, 32'h1000, 32'h0);
    last_gnt = 0;
    expect_txn(0, 1'b0, 32'h1000, 32'h0, 1'b1);
    chk("oor.rdata0", bus.rdata0, 32'h0);

    // Reset asserted during RESP of a port 1 read
    drive(1, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    @(negedge clk);
    bus.req1 = 0;
    @(negedge clk);
    chk("rstresp.pre.ctrl", ctrl_obs(), 32'h01);
    rst_n = 1'b0;
    #1;
    exp_rdata[0] = 0; exp_rdata[1] = 0;
    last_gnt = 1;
    check_cycle("rstresp.async", 8'h00, 32'h0, 32'h0);
    repeat (2) begin
      @(negedge clk);
      check_cycle("rstresp.hold", 8'h00, 32'h0, 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_cycle("rstresp.after", 8'h00, 32'h0, 32'h0);
    drive(0, 1'b0, 32'h40, 32'h0);
    last_gnt = 0;
    expect_txn(0, 1'b0, 32'h40, 32'h0, 1'b1);
    chk("rstresp.rdata0", bus.rdata0, 32'h12345678);

    // Misaligned read maps to word 4
    drive(0, 1'b0, 32'h13, 32'h0);
    last_gnt = 0;
    expect_txn(0, 1'b0, 32'h13, 32'h0, 1'b1);
    chk("mis13.rdata0", bus.rdata0, 32'hDEADBEEF);

    // Randomized mix of reads, writes, conflicts and out-of-range accesses
    pend[0] = 0; pend[1] = 0;
    for (int it = 0; it < 60; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          pwe[p] = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 7) == 0) pad[p] = 32'h1000 + $urandom_range(0, 32'hFFFF);
          else pad[p] = ($urandom_range(0, 1023) << 2) | $urandom_range(0, 3);
          pwd[p] = $urandom;
          drive(p, pwe[p], pad[p], pwd[p]);
          pend[p] = 1;
        end
      end
      if (!pend[0] && !pend[1]) begin
        @(negedge clk);
      end else begin
        w = pick(pend[0], pend[1]);
        last_gnt = w;
        expect_txn(w, pwe[w], pad[w], pwd[w], 1'b1);
        pend[w] = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the shared data memory (1024 x 32, word-addressed internally, registered read with output gated by MemRead). It accepts word-access requests from port 0 (processor data port) and port 1 (debug/loader port), grants one at a time, drives the memory's address/data/strobe inputs, and returns read data and a completion pulse to the winner. It sits between the core's memory stage and the data memory.

## Interface

- MEM_WORDS, 1024: memory depth in 32-bit words; byte addresses at or above MEM_WORDS*4 are out of range.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req0 / req1  input  1  access request, held with its qualifiers until gnt seen
- we0 / we1  input  1  1 = write, 0 = read
- addr0 / addr1  input  32  byte address
- wdata0 / wdata1  input  32  write data
- gnt0 / gnt1  output  1  one-cycle pulse: request accepted, qualifiers latched
- done0 / done1  output  1  one-cycle pulse: access complete
- rdata0 / rdata1  output  32  read result, valid with done, held until the port's next read done
- err0 / err1  output  1  one-cycle pulse with done: access was out of range, memory untouched
- memAddr  output  32  to memory, byte address
- memWriteData  output  32  to memory
- MemWrite / MemRead  output  1  to memory strobes
- memReadData  input  32  from memory

## Operation

- States: IDLE, ACCESS, RESP, DONE.
- IDLE: sample req0/req1 at the clock edge. If any asserted, latch winner's we/addr/wdata, set owner, go to ACCESS. Else stay.
- Arbitration, fixed priority: port 0 wins a simultaneous request.
- ACCESS (one cycle): gnt[owner]=1. If address in range: memAddr=latched addr, memWriteData=latched wdata (reads: 0), MemWrite=we, MemRead=~we. Next state: RESP for in-range read, DONE otherwise. Out-of-range: all memory outputs 0, err flagged.
- RESP (one cycle): MemRead held 1, memAddr held; memReadData captured into rdata[owner] at the edge ending RESP. Next DONE.
- DONE (one cycle): done[owner]=1, err[owner]=1 if flagged. Out-of-range read writes rdata[owner]=0. Memory outputs 0. Next IDLE.
- Non-owner's rdata never changes. Write does not alter rdata.
- Requests arriving during ACCESS/RESP/DONE wait; only IDLE samples. Requester must drop req the cycle after gnt or it is a new request.
- Range check: addr >= MEM_WORDS*4 is out of range. Bits [1:0] ignored (memory word-aligns), not an error.

## Timing

- Reset (async assert, sync release): state IDLE, all gnt/done/err 0, rdata0/rdata1 = 0, memAddr/memWriteData = 0, MemWrite/MemRead = 0, round-robin pointer = port 1 last granted. In-flight access dropped, no done issued. A write in ACCESS at reset assertion may be lost.
- Read, req sampled end of cycle N: gnt N+1, memory capture end of N+1, RESP N+2, done+rdata N+3, IDLE N+4 (4 cycles request to next sample).
- Write: gnt N+1, memory write at end of N+1, done N+2, IDLE N+3.
- Out of range (read or write): gnt N+1, done+err N+2.
- Exactly one of gnt0/gnt1 per transaction; gnt and done never both high in one cycle.

## Configuration

- DMEM_ARB_RR_EN defined: round-robin. Pointer records last-granted port, updated at each grant. On simultaneous request, the port not last granted wins; single requester always wins. After reset port 0 wins the first conflict.
- Undefined: fixed priority, port 0 always wins; pointer logic absent.

## Test plan

- Reset then port 0 read addr 0x10 with memory word 4 = 0xDEADBEEF -> gnt0 at N+1, MemRead=1 in N+1 and N+2, done0 with rdata0=0xDEADBEEF at N+3, rdata1 stays 0.
- Port 1 write 0x0000_0040 data 0x12345678, then port 0 read 0x40 -> MemWrite=1 only in port 1's ACCESS cycle, done1 at N+2, later rdata0=0x12345678.
- req0 and req1 both held high continuously, reads -> without DMEM_ARB_RR_EN port 0 granted every transaction; with it grants alternate 0,1,0,1.
- Port 0 read addr 0x1000 (MEM_WORDS=1024) -> gnt0 N+1, MemRead/MemWrite stay 0, done0 and err0 at N+2, rdata0=0.
- rst_n asserted low during RESP of a port 1 read -> all outputs zero immediately, no done1, after release next req0 serviced normally with correct data.
- Misaligned read 0x13 -> memAddr=0x13, no err, rdata0 = word 4.
